// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Register indices and reset values for the irq_ctrl block.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    localparam logic [2:0] REG_PENDING   = 3'd0;
    localparam logic [2:0] REG_ENABLE    = 3'd1;
    localparam logic [2:0] REG_MODE      = 3'd2;
    localparam logic [2:0] REG_POLARITY  = 3'd3;
    localparam logic [2:0] REG_ACTIVE_ID = 3'd4;

    localparam logic [7:0] ACTIVE_NONE   = 8'hFF;

    // Sized for the maximum of 8 lines; sliced down to N_IRQ at use.
    localparam logic [7:0] RST_PENDING   = 8'h00;
    localparam logic [7:0] RST_ENABLE    = 8'h00;
    localparam logic [7:0] RST_MODE      = 8'hFF;
    localparam logic [7:0] RST_POLARITY  = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Per-line synchroniser, polarity normalisation and rising-edge
//               detector with history reload on configuration writes.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    input  logic i_pol,
    input  logic i_reload,
    input  logic i_reload_pol,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            // On a MODE/POLARITY write, preload history with the level the new
            // polarity will produce next cycle so no false edge appears.
            if (i_reload) begin
                r_prev <= r_sync[SYNC_STAGES-2] ~^ i_reload_pol;
            end else begin
                r_prev <= o_level;
            end
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1] ~^ i_pol;
    assign o_rise  = o_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Memory-mapped interrupt controller feeding the picoRV32 irq
//               vector: edge/level detection, pending, enable and priority.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ       = 3,
    parameter int IRQ_BASE    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             sel,
    input  logic             mem_valid,
    input  logic [2:0]       mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_rdata,
    output logic             mem_ready,
    input  logic [31:0]      eoi,
    output logic [31:0]      cpu_irq
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACK  = 1'b1;

    logic             r_state;
    logic             w_state_next;
    logic [2:0]       r_addr;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_enable;
    logic [N_IRQ-1:0] r_mode;
    logic [N_IRQ-1:0] r_polarity;
    logic [31:0]      r_cpu_irq;

    logic             w_start;
    logic             w_wr;
    logic             w_wr_pend;
    logic             w_wr_en;
    logic             w_wr_mode;
    logic             w_wr_pol;
    logic             w_reload;
    logic [N_IRQ-1:0] w_pol_next;
    logic [N_IRQ-1:0] w_level;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_pending_next;
    logic [7:0]       w_active_id;
    logic [31:0]      w_rdata;
    logic [31:0]      w_irq_next;
    logic             w_unused;

    assign w_unused = ^{mem_wstrb[3:1], mem_wdata, eoi};

    // ---------------- bus FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_addr <= mem_addr;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (r_state == ST_ACK);
    end

    assign w_start   = sel & mem_valid & ~mem_ready;
    assign w_wr      = w_start & mem_wstrb[0];
    assign w_wr_pend = w_wr & (mem_addr == REG_PENDING);
    assign w_wr_en   = w_wr & (mem_addr == REG_ENABLE);
    assign w_wr_mode = w_wr & (mem_addr == REG_MODE);
    assign w_wr_pol  = w_wr & (mem_addr == REG_POLARITY);
    assign w_reload  = w_wr_mode | w_wr_pol;
    assign w_pol_next = w_wr_pol ? mem_wdata[N_IRQ-1:0] : r_polarity;

    // ---------------- input conditioning ----------------
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk          (clk),
            .rst          (reset),
            .i_irq        (irq_in[gi]),
            .i_pol        (r_polarity[gi]),
            .i_reload     (w_reload),
            .i_reload_pol (w_pol_next[gi]),
            .o_level      (w_level[gi]),
            .o_rise       (w_rise[gi])
        );
    end

    // Edge lines: a new edge beats any simultaneous clear.
    always_comb begin
        w_clr = eoi[IRQ_BASE +: N_IRQ];
        if (w_wr_pend) begin
            w_clr = w_clr | mem_wdata[N_IRQ-1:0];
        end
        for (int i = 0; i < N_IRQ; i++) begin
            w_pending_next[i] = r_mode[i] ? (w_rise[i] | (r_pending[i] & ~w_clr[i]))
                                          : w_level[i];
        end
    end

    always_comb begin
        w_irq_next = '0;
        w_irq_next[IRQ_BASE +: N_IRQ] = r_pending & r_enable;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= RST_PENDING[N_IRQ-1:0];
            r_enable   <= RST_ENABLE[N_IRQ-1:0];
            r_mode     <= RST_MODE[N_IRQ-1:0];
            r_polarity <= RST_POLARITY[N_IRQ-1:0];
            r_cpu_irq  <= '0;
        end else begin
            r_pending  <= w_pending_next;
            r_polarity <= w_pol_next;
            r_cpu_irq  <= w_irq_next;
            if (w_wr_en) begin
                r_enable <= mem_wdata[N_IRQ-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= mem_wdata[N_IRQ-1:0];
            end
        end
    end

    assign cpu_irq = r_cpu_irq;

    // Lowest-numbered enabled pending line wins.
    always_comb begin
        w_active_id = ACTIVE_NONE;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (r_pending[i] & r_enable[i]) begin
                w_active_id = 8'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (mem_ready) begin
            case (r_addr)
                REG_PENDING:   w_rdata[N_IRQ-1:0] = r_pending;
                REG_ENABLE:    w_rdata[N_IRQ-1:0] = r_enable;
                REG_MODE:      w_rdata[N_IRQ-1:0] = r_mode;
                REG_POLARITY:  w_rdata[N_IRQ-1:0] = r_polarity;
                REG_ACTIVE_ID: w_rdata[7:0]       = w_active_id;
                default:       w_rdata            = '0;
            endcase
        end
    end

    assign mem_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  irq_in;
    logic        sel;
    logic        mem_valid;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] eoi;
    logic [31:0] cpu_irq;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] irq_at_ack;
    logic [31:0] rd_data;

    irq_ctrl #(
        .N_IRQ       (3),
        .IRQ_BASE    (5),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .eoi       (eoi),
        .cpu_irq   (cpu_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic [2:0] idx, input logic [31:0] wd,
                            input logic [3:0] ws, output logic [31:0] rd);
        sel       = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = idx;
        mem_wdata = wd;
        mem_wstrb = ws;
        check("rdy_before", 32'(mem_ready), 32'd0);
        tick();
        check("rdy_ack", 32'(mem_ready), 32'd1);
        rd         = mem_rdata;
        irq_at_ack = cpu_irq;
        sel        = 1'b0;
        mem_valid  = 1'b0;
        mem_wstrb  = 4'h0;
        tick();
        check("rdy_drop", 32'(mem_ready), 32'd0);
        check("rdata_idle", mem_rdata, 32'd0);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_xfer(idx, wd, 4'h1, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        bus_xfer(idx, 32'd0, 4'h0, d);
        check(tag, d, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; irq_in = 3'b000; sel = 1'b0; mem_valid = 1'b0;
        mem_addr = 3'd0; mem_wdata = 32'd0; mem_wstrb = 4'h0; eoi = 32'd0;
        irq_at_ack = 32'd0; rd_data = 32'd0;
        repeat (3) tick();
        check("rst_cpu_irq", cpu_irq, 32'd0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        reset = 1'b0;
        tick();
        rd_chk("rst_pend", REG_PENDING, 32'h0);
        rd_chk("rst_en", REG_ENABLE, 32'h0);
        rd_chk("rst_mode", REG_MODE, 32'h7);
        rd_chk("rst_pol", REG_POLARITY, 32'h7);
        rd_chk("rst_active", REG_ACTIVE_ID, 32'hFF);

        // Latency: sync(2) + pending + output register = 4 edges.
        wr(REG_ENABLE, 32'h1);
        irq_in = 3'b001;
        repeat (3) tick();
        check("lat_early", cpu_irq, 32'h0);
        tick();
        check("lat_rise", cpu_irq, 32'h20);
        repeat (16) tick();
        irq_in = 3'b000;
        rd_chk("lat_pend", REG_PENDING, 32'h1);
        rd_chk("lat_active", REG_ACTIVE_ID, 32'h0);
        wr(REG_PENDING, 32'h1);
        rd_chk("w1c_pend", REG_PENDING, 32'h0);
        check("w1c_irq", cpu_irq, 32'h0);

        // Priority and clear.
        wr(REG_ENABLE, 32'h7);
        irq_in = 3'b100; repeat (3) tick();
        irq_in = 3'b000; repeat (2) tick();
        irq_in = 3'b010; repeat (3) tick();
        irq_in = 3'b000; repeat (6) tick();
        rd_chk("pri_pend", REG_PENDING, 32'h6);
        rd_chk("pri_active1", REG_ACTIVE_ID, 32'h1);
        check("pri_irq", cpu_irq, 32'hC0);
        wr(REG_PENDING, 32'h2);
        rd_chk("pri_pend2", REG_PENDING, 32'h4);
        rd_chk("pri_active2", REG_ACTIVE_ID, 32'h2);
        eoi = 32'h80; tick();
        eoi = 32'h0;  tick();
        check("eoi_irq", cpu_irq, 32'h0);
        rd_chk("eoi_pend", REG_PENDING, 32'h0);
        rd_chk("eoi_active", REG_ACTIVE_ID, 32'hFF);

        // Level mode.
        wr(REG_MODE, 32'h0);
        irq_in = 3'b101; repeat (5) tick();
        rd_chk("lvl_hi_pend", REG_PENDING, 32'h5);
        wr(REG_POLARITY, 32'h0);
        repeat (3) tick();
        check("lvl_low_irq", cpu_irq, 32'h40);
        rd_chk("lvl_low_pend", REG_PENDING, 32'h2);
        wr(REG_PENDING, 32'h2);
        rd_chk("lvl_w1c", REG_PENDING, 32'h2);
        eoi = 32'h40; tick(); eoi = 32'h0;
        rd_chk("lvl_eoi", REG_PENDING, 32'h2);
        irq_in = 3'b111;
        repeat (3) tick();
        check("lvl_hold", cpu_irq, 32'h40);
        tick();
        check("lvl_drop", cpu_irq, 32'h0);
        irq_in = 3'b000; repeat (4) tick();
        wr(REG_POLARITY, 32'h7);
        wr(REG_MODE, 32'h7);
        repeat (2) tick();
        rd_chk("restore_pend", REG_PENDING, 32'h0);
        check("restore_irq", cpu_irq, 32'h0);

        // Set-wins: edge lands on the same edge as the W1C commit.
        irq_in = 3'b001;
        tick(); tick();
        wr(REG_PENDING, 32'h1);
        rd_chk("race_pend", REG_PENDING, 32'h1);
        check("race_irq", cpu_irq, 32'h20);
        wr(REG_PENDING, 32'h1);
        rd_chk("race_clr", REG_PENDING, 32'h0);
        irq_in = 3'b000; repeat (4) tick();

        // Masking and bus details.
        wr(REG_ENABLE, 32'h0);
        irq_in = 3'b100; repeat (3) tick();
        irq_in = 3'b000; repeat (4) tick();
        check("mask_irq", cpu_irq, 32'h0);
        rd_chk("mask_pend", REG_PENDING, 32'h4);
        wr(REG_ENABLE, 32'h4);
        check("mask_at_ack", irq_at_ack, 32'h0);
        check("mask_on", cpu_irq, 32'h80);
        rd_chk("idx6_rd", 3'd6, 32'h0);
        wr(3'd6, 32'hFFFF_FFFF);
        rd_chk("idx6_after_wr", 3'd6, 32'h0);
        bus_xfer(REG_ENABLE, 32'h0, 4'h2, rd_data);
        rd_chk("wstrb_ignored", REG_ENABLE, 32'h4);

        // Reset in the middle of a write request.
        sel = 1'b1; mem_valid = 1'b1; mem_addr = REG_MODE;
        mem_wdata = 32'h0; mem_wstrb = 4'h1; reset = 1'b1;
        tick();
        check("rstx_ready", 32'(mem_ready), 32'd0);
        check("rstx_irq", cpu_irq, 32'h0);
        sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        tick();
        reset = 1'b0;
        tick();
        check("rstx_irq2", cpu_irq, 32'h0);
        rd_chk("rstx_mode", REG_MODE, 32'h7);
        rd_chk("rstx_en", REG_ENABLE, 32'h0);
        rd_chk("rstx_pend", REG_PENDING, 32'h0);
        rd_chk("rstx_pol", REG_POLARITY, 32'h7);
        rd_chk("rstx_active", REG_ACTIVE_ID, 32'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
